envelope_vca: RTL and testbench

- ADSR envelope generator with a voltage-controlled amplifier (VCA) stage.
- Sits directly downstream of the sinusoid oscillator and consumes its signed 16Q.16 wave at the oscillator update rate (1 MHz strobe).
- Shapes the wave's amplitude with a gate-driven attack/decay/sustain/release envelope.
- Feeds the scaled wave to the mixer/DAC path.

---
 rtl/envelope_vca.sv | 166 ++++++++++++++++
 tb/tb_envelope_vca.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// ADSR envelope generator driving a two-stage VCA multiplier.
// The envelope advances once per oscillator sample tick; the scaled wave emerges two enabled edges later.
module envelope_vca #(
    parameter int DATA_W = 32,
    parameter int LVL_W  = 16
) (
    input  logic              sys_clk_i,
    input  logic              env_rst_n_i,
    input  logic              env_ce_i,
    input  logic              sample_stb_i,
    input  logic              gate_i,
    input  logic [LVL_W-1:0]  attack_rate_i,
    input  logic [LVL_W-1:0]  decay_rate_i,
    input  logic [LVL_W-1:0]  sustain_lvl_i,
    input  logic [LVL_W-1:0]  release_rate_i,
    input  logic [DATA_W-1:0] wave_in_i,
    output logic [DATA_W-1:0] wave_out_o,
    output logic              wave_valid_o,
    output logic [LVL_W-1:0]  env_level_o,
    output logic [2:0]        env_state_o,
    output logic              env_busy_o
);

    // state   | meaning
    // IDLE    | silent, waiting for a gate rise
    // ATTACK  | level ramps up by attack_rate per tick until full scale
    // DECAY   | level ramps down by decay_rate per tick until sustain
    // SUSTAIN | level follows sustain_lvl while the gate is held
    // RELEASE | level ramps down by release_rate per tick until zero
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam int PROD_W = DATA_W + LVL_W + 1;
    localparam logic [LVL_W-1:0]      LVL_MAX   = {LVL_W{1'b1}};
    localparam logic signed [LVL_W:0] DIFF_ZERO = '0;

    env_state_t                 state_q;
    logic [LVL_W-1:0]           level_q;
    logic                       gate_prev_q;

    logic                       tick;
    logic                       rise;
    logic [LVL_W:0]             atk_sum;
    logic signed [LVL_W:0]      dec_diff;
    logic signed [LVL_W:0]      rel_diff;
    logic signed [LVL_W:0]      sus_ext;

    logic signed [DATA_W-1:0]   wave_q;
    logic [LVL_W-1:0]           lvl_q;
    logic                       v1_q;
    logic signed [PROD_W-1:0]   prod_q;
    logic                       v2_q;
    logic [DATA_W-1:0]          out_q;
    logic                       valid_q;
    logic                       unused_prod;

    assign tick     = env_ce_i & sample_stb_i;
    assign rise     = gate_i & ~gate_prev_q;
    assign atk_sum  = {1'b0, level_q} + {1'b0, attack_rate_i};
    assign dec_diff = $signed({1'b0, level_q}) - $signed({1'b0, decay_rate_i});
    assign rel_diff = $signed({1'b0, level_q}) - $signed({1'b0, release_rate_i});
    assign sus_ext  = $signed({1'b0, sustain_lvl_i});

    // Transition ticks keep the level except where a ramp clamps onto its target.
    always_ff @(posedge sys_clk_i or negedge env_rst_n_i) begin
        if (!env_rst_n_i) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            gate_prev_q <= 1'b0;
        end else if (tick) begin
            gate_prev_q <= gate_i;
            if (rise) begin
                state_q <= ST_ATTACK;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_ATTACK: begin
                        if (!gate_i) begin
                            state_q <= ST_RELEASE;
                        end else if (atk_sum >= {1'b0, LVL_MAX}) begin
                            level_q <= LVL_MAX;
                            state_q <= ST_DECAY;
                        end else begin
                            level_q <= atk_sum[LVL_W-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if (!gate_i) begin
                            state_q <= ST_RELEASE;
                        end else if (dec_diff <= sus_ext) begin
                            level_q <= sustain_lvl_i;
                            state_q <= ST_SUSTAIN;
                        end else begin
                            level_q <= dec_diff[LVL_W-1:0];
                        end
                    end
                    ST_SUSTAIN: begin
                        if (!gate_i) begin
                            state_q <= ST_RELEASE;
                        end else begin
                            level_q <= sustain_lvl_i;
                        end
                    end
                    ST_RELEASE: begin
                        if (rel_diff <= DIFF_ZERO) begin
                            level_q <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            level_q <= rel_diff[LVL_W-1:0];
                        end
                    end
                    default: begin
                        level_q <= '0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // lvl_q samples the level as it stood before this tick's envelope update.
    always_ff @(posedge sys_clk_i or negedge env_rst_n_i) begin
        if (!env_rst_n_i) begin
            wave_q  <= '0;
            lvl_q   <= '0;
            v1_q    <= 1'b0;
            prod_q  <= '0;
            v2_q    <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (env_ce_i) begin
            if (sample_stb_i) begin
                wave_q <= $signed(wave_in_i);
                lvl_q  <= level_q;
            end
            v1_q <= sample_stb_i;
            if (v1_q) begin
                prod_q <= wave_q * $signed({1'b0, lvl_q});
            end
            v2_q <= v1_q;
            if (v2_q) begin
                out_q <= prod_q[DATA_W+LVL_W-1:LVL_W];
            end
            valid_q <= v2_q;
        end else begin
            valid_q <= 1'b0;
        end
    end

    // Sign bit and fractional bits of the product fall outside the Q16.16 result.
    assign unused_prod = ^{prod_q[PROD_W-1], prod_q[LVL_W-1:0]};

    assign wave_out_o   = out_q;
    assign wave_valid_o = valid_q & env_ce_i;
    assign env_level_o  = level_q;
    assign env_state_o  = state_q;
    assign env_busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca: envelope stepping, VCA scaling, pipeline timing, enable hold, async reset.
module tb_envelope_vca;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        stb;
    logic        gate;
    logic [15:0] atk_rate;
    logic [15:0] dec_rate;
    logic [15:0] sus_lvl;
    logic [15:0] rel_rate;
    logic [31:0] wave_in;
    logic [31:0] wave_out;
    logic        wave_valid;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        env_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    envelope_vca dut (
        .sys_clk_i     (clk),
        .env_rst_n_i   (rst_n),
        .env_ce_i      (ce),
        .sample_stb_i  (stb),
        .gate_i        (gate),
        .attack_rate_i (atk_rate),
        .decay_rate_i  (dec_rate),
        .sustain_lvl_i (sus_lvl),
        .release_rate_i(rel_rate),
        .wave_in_i     (wave_in),
        .wave_out_o    (wave_out),
        .wave_valid_o  (wave_valid),
        .env_level_o   (env_level),
        .env_state_o   (env_state),
        .env_busy_o    (env_busy)
    );

    // One-cycle strobe; returns at the negedge after the ticking posedge.
    task automatic tick();
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic test_reset_initial();
        rst_n = 1'b0; ce = 1'b1; stb = 1'b0; gate = 1'b0;
        atk_rate = '0; dec_rate = '0; sus_lvl = '0; rel_rate = '0; wave_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (env_state !== 3'd0) begin errors++; $display("FAIL init_state got %0d want 0", env_state); end
        checks++; if (env_level !== 16'h0000) begin errors++; $display("FAIL init_level got %h want 0000", env_level); end
        checks++; if (wave_valid !== 1'b0 || env_busy !== 1'b0) begin errors++; $display("FAIL init_flags got valid=%b busy=%b want 0 0", wave_valid, env_busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_attack();
        logic [15:0] exp_l [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        logic [2:0]  exp_s [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        atk_rate = 16'h4000;
        gate = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (env_level !== exp_l[i]) begin errors++; $display("FAIL attack_level t%0d got %h want %h", i + 1, env_level, exp_l[i]); end
            checks++; if (env_state !== exp_s[i]) begin errors++; $display("FAIL attack_state t%0d got %0d want %0d", i + 1, env_state, exp_s[i]); end
        end
    endtask

    task automatic test_decay_sustain();
        dec_rate = 16'h1000;
        sus_lvl  = 16'hE000;
        tick();
        checks++; if (env_level !== 16'hEFFF || env_state !== 3'd2) begin errors++; $display("FAIL decay_step got %h/%0d want EFFF/2", env_level, env_state); end
        tick();
        checks++; if (env_level !== 16'hE000 || env_state !== 3'd3) begin errors++; $display("FAIL decay_clamp got %h/%0d want E000/3", env_level, env_state); end
        sus_lvl = 16'hA000;
        tick();
        checks++; if (env_level !== 16'hA000 || env_state !== 3'd3) begin errors++; $display("FAIL sustain_track got %h/%0d want A000/3", env_level, env_state); end
    endtask

    task automatic test_release_retrigger();
        sus_lvl = 16'hE000;
        tick();
        checks++; if (env_level !== 16'hE000) begin errors++; $display("FAIL sustain_e000 got %h want E000", env_level); end
        rel_rate = 16'h8000;
        gate = 1'b0;
        tick();
        checks++; if (env_level !== 16'hE000 || env_state !== 3'd4) begin errors++; $display("FAIL release_t1 got %h/%0d want E000/4", env_level, env_state); end
        tick();
        checks++; if (env_level !== 16'h6000 || env_state !== 3'd4) begin errors++; $display("FAIL release_t2 got %h/%0d want 6000/4", env_level, env_state); end
        gate = 1'b1;
        tick();
        checks++; if (env_level !== 16'h6000 || env_state !== 3'd1 || env_busy !== 1'b1) begin errors++; $display("FAIL retrigger got %h/%0d/%b want 6000/1/1", env_level, env_state, env_busy); end
        gate = 1'b0;
        tick();
        checks++; if (env_level !== 16'h6000 || env_state !== 3'd4) begin errors++; $display("FAIL attack_to_release got %h/%0d want 6000/4", env_level, env_state); end
        tick();
        checks++; if (env_level !== 16'h0000 || env_state !== 3'd0 || env_busy !== 1'b0) begin errors++; $display("FAIL release_end got %h/%0d/%b want 0000/0/0", env_level, env_state, env_busy); end
    endtask

    task automatic test_vca();
        logic [15:0] sus_v [3] = '{16'h8000, 16'h8000, 16'hFFFF};
        logic [31:0] win_v [3] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000};
        logic [31:0] exp_v [3] = '{32'h0000_8000, 32'hFFFF_8000, 32'h0000_FFFF};
        atk_rate = 16'hFFFF;
        dec_rate = 16'hFFFF;
        sus_lvl  = 16'h8000;
        gate     = 1'b1;
        repeat (4) tick();
        checks++; if (env_level !== 16'h8000 || env_state !== 3'd3) begin errors++; $display("FAIL vca_setup got %h/%0d want 8000/3", env_level, env_state); end
        for (int i = 0; i < 3; i++) begin
            sus_lvl = sus_v[i];
            tick();
            repeat (3) @(negedge clk);
            wave_in = win_v[i];
            stb = 1'b1;
            @(negedge clk);
            stb = 1'b0; wave_in = '0;
            checks++; if (wave_valid !== 1'b0) begin errors++; $display("FAIL vca%0d_valid_e0 got %b want 0", i, wave_valid); end
            @(negedge clk);
            checks++; if (wave_valid !== 1'b0) begin errors++; $display("FAIL vca%0d_valid_e1 got %b want 0", i, wave_valid); end
            @(negedge clk);
            checks++; if (wave_valid !== 1'b1 || wave_out !== exp_v[i]) begin errors++; $display("FAIL vca%0d_out got %h valid=%b want %h valid=1", i, wave_out, wave_valid, exp_v[i]); end
            @(negedge clk);
            checks++; if (wave_valid !== 1'b0 || wave_out !== exp_v[i]) begin errors++; $display("FAIL vca%0d_hold got %h valid=%b want %h valid=0", i, wave_out, wave_valid, exp_v[i]); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wave_in = 32'h0001_0000; stb = 1'b1;
        @(negedge clk);
        wave_in = 32'h0002_0000;
        @(negedge clk);
        stb = 1'b0; wave_in = '0;
        @(negedge clk);
        checks++; if (wave_valid !== 1'b1 || wave_out !== 32'h0000_FFFF) begin errors++; $display("FAIL b2b_first got %h valid=%b want 0000ffff valid=1", wave_out, wave_valid); end
        @(negedge clk);
        checks++; if (wave_valid !== 1'b1 || wave_out !== 32'h0001_FFFE) begin errors++; $display("FAIL b2b_second got %h valid=%b want 0001fffe valid=1", wave_out, wave_valid); end
        @(negedge clk);
        checks++; if (wave_valid !== 1'b0) begin errors++; $display("FAIL b2b_after got valid=%b want 0", wave_valid); end
    endtask

    task automatic test_enable();
        int lat;
        @(negedge clk);
        wave_in = 32'h0003_0000; stb = 1'b1;
        @(negedge clk);
        ce = 1'b0; gate = 1'b0; wave_in = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (env_level !== 16'hFFFF || env_state !== 3'd3) begin errors++; $display("FAIL ce_hold_env c%0d got %h/%0d want FFFF/3", i, env_level, env_state); end
            checks++; if (wave_out !== 32'h0001_FFFE || wave_valid !== 1'b0) begin errors++; $display("FAIL ce_hold_out c%0d got %h valid=%b want 0001fffe valid=0", i, wave_out, wave_valid); end
        end
        ce = 1'b1; stb = 1'b0; gate = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(negedge clk);
            if (wave_valid === 1'b1) lat = i;
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL ce_resume_latency got %0d want 2", lat); end
        checks++; if (wave_out !== 32'h0002_FFFD) begin errors++; $display("FAIL ce_resume_out got %h want 0002fffd", wave_out); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        atk_rate = 16'h4000;
        gate = 1'b1;
        wave_in = 32'h0001_0000;
        repeat (3) tick();
        repeat (2) @(negedge clk);
        checks++; if (env_level !== 16'h8000 || env_state !== 3'd1) begin errors++; $display("FAIL rst_pre_env got %h/%0d want 8000/1", env_level, env_state); end
        checks++; if (wave_out !== 32'h0000_4000) begin errors++; $display("FAIL rst_pre_out got %h want 00004000", wave_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (env_level !== 16'h0000 || env_state !== 3'd0 || env_busy !== 1'b0) begin errors++; $display("FAIL rst_async_env got %h/%0d/%b want 0000/0/0", env_level, env_state, env_busy); end
        checks++; if (wave_out !== 32'h0 || wave_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out got %h valid=%b want 0 valid=0", wave_out, wave_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset_initial();
        test_attack();
        test_decay_sustain();
        test_release_retrigger();
        test_vca();
        test_back_to_back();
        test_enable();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
